// File: rtl/wb_pkg.sv
// Shared types for the ping-pong weight buffer: bank state encoding and row width.
package wb_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  function automatic int row_width(input int n_cols, input int data_width);
    return n_cols * data_width;
  endfunction

endpackage

// File: rtl/wb_bank_ram.sv
// One weight bank: single write port plus a registered read port.
// The read register is reset so the drained-row output starts at zero; the array itself is not.
module wb_bank_ram
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_COLS     = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  localparam int ROW_W     = row_width(N_COLS, DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [ROW_W-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [ROW_W-1:0]      rdata_o
);

  logic [ROW_W-1:0] mem_q [DEPTH];
  logic [ROW_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Holds the last row read while idle, which keeps the buffer output stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_weight_buffer.sv
// Double-buffered weight store: host fills one bank while the array drains the other.
//   state         | meaning
//   BANK_EMPTY    | free; next accepted beat writes row 0
//   BANK_FILLING  | tile partially written
//   BANK_FULL     | tile complete, waiting for rd_start
//   BANK_DRAINING | rows being issued to the read port
module pingpong_weight_buffer
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_COLS     = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  localparam int ROW_W     = row_width(N_COLS, DATA_WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [ROW_W-1:0] wr_data_i,
  input  logic             wr_last_i,
  input  logic             rd_start_i,
  output logic             rd_busy_o,
  output logic             rd_valid_o,
  output logic [ROW_W-1:0] rd_data_o,
  output logic             rd_last_o,
  output logic [1:0]       bank_full_o,
  output logic             ovf_err_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH:0]   ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

  bank_state_e           bank_q  [2];
  logic [ADDR_WIDTH:0]   count_q [2];
  logic                  wb_q, rb_q, rd_sel_q;
  logic                  ovf_q, rd_valid_q, rd_last_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;

  logic [ADDR_WIDTH-1:0] wr_row_d;
  logic                  wr_fire, wr_close, rd_fire, drain_active, rd_final;
  logic [ROW_W-1:0]      rdata [2];

  assign wr_ready_o   = (bank_q[wb_q] == BANK_EMPTY) || (bank_q[wb_q] == BANK_FILLING);
  assign wr_fire      = wr_valid_i && wr_ready_o;
  assign wr_row_d     = (bank_q[wb_q] == BANK_EMPTY) ? '0 : wr_addr_q;
  assign wr_close     = wr_last_i || (wr_row_d == LAST_ROW);

  assign drain_active = (bank_q[rb_q] == BANK_DRAINING);
  assign rd_fire      = rd_start_i && !drain_active && (bank_q[rb_q] == BANK_FULL);
  assign rd_final     = (({1'b0, rd_addr_q}) + ONE) == count_q[rb_q];

  // The pointers only touch a bank in disjoint states (write: EMPTY/FILLING,
  // read: FULL/DRAINING), so both may update in the same cycle without conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        bank_q[i]  <= BANK_EMPTY;
        count_q[i] <= '0;
      end
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      rd_sel_q   <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= drain_active;
      rd_last_q  <= drain_active && rd_final;

      if (wr_fire) begin
        if (wr_close) begin
          bank_q[wb_q]  <= BANK_FULL;
          count_q[wb_q] <= {1'b0, wr_row_d} + ONE;
          wb_q          <= ~wb_q;
          wr_addr_q     <= '0;
          if (!wr_last_i) ovf_q <= 1'b1;
        end else begin
          bank_q[wb_q] <= BANK_FILLING;
          wr_addr_q    <= wr_row_d + 1'b1;
        end
      end

      if (rd_fire) begin
        bank_q[rb_q] <= BANK_DRAINING;
        rd_addr_q    <= '0;
      end else if (drain_active) begin
        rd_sel_q <= rb_q;
        if (rd_final) begin
          bank_q[rb_q] <= BANK_EMPTY;
          rb_q         <= ~rb_q;
        end else begin
          rd_addr_q <= rd_addr_q + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    wb_bank_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .N_COLS     (N_COLS),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (wr_fire && (wb_q == 1'(g))),
      .waddr_i (wr_row_d),
      .wdata_i (wr_data_i),
      .re_i    (drain_active && (rb_q == 1'(g))),
      .raddr_i (rd_addr_q),
      .rdata_o (rdata[g])
    );
  end

  assign rd_busy_o   = drain_active;
  assign rd_valid_o  = rd_valid_q;
  assign rd_last_o   = rd_last_q;
  assign rd_data_o   = rd_sel_q ? rdata[1] : rdata[0];
  assign bank_full_o = {bank_q[1] == BANK_FULL, bank_q[0] == BANK_FULL};
  assign ovf_err_o   = ovf_q;

endmodule

// File: tb/tb_pingpong_weight_buffer.sv
// Bench for pingpong_weight_buffer: directed scenarios plus random traffic against a tile-queue model.
module tb_pingpong_weight_buffer;

  localparam int DATA_WIDTH = 16;
  localparam int N_COLS     = 8;
  localparam int DEPTH      = 4;
  localparam int ROW_W      = DATA_WIDTH * N_COLS;

  typedef logic [ROW_W-1:0] row_t;
  typedef struct { int t; row_t d; bit l; } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       wr_valid_i = 1'b0;
  logic       wr_last_i = 1'b0;
  logic       rd_start_i = 1'b0;
  row_t       wr_data_i = '0;
  logic       wr_ready_o, rd_busy_o, rd_valid_o, rd_last_o, ovf_err_o;
  row_t       rd_data_o;
  logic [1:0] bank_full_o;

  always #5 clk_i = ~clk_i;

  pingpong_weight_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_COLS     (N_COLS),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_data_i   (wr_data_i),
    .wr_last_i   (wr_last_i),
    .rd_start_i  (rd_start_i),
    .rd_busy_o   (rd_busy_o),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .rd_last_o   (rd_last_o),
    .bank_full_o (bank_full_o),
    .ovf_err_o   (ovf_err_o)
  );

  // Model: completed tiles queue up in write order; a drain occupies a window of cycles.
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bs = 1, be = 0;
  int   tile_ctr = 0;
  bit   ovf_m = 1'b0;
  row_t last_d = '0;
  row_t part[$];
  row_t fullrows[$];
  int   fulllen[$];
  bit   fullbank[$];
  exp_t expq[$];

  task automatic chk(input string tag, input row_t obs, input row_t exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit model_busy();
    return (cyc >= bs) && (cyc <= be);
  endfunction

  function automatic bit model_ready();
    return (fulllen.size() + (model_busy() ? 1 : 0)) < 2;
  endfunction

  function automatic row_t rnd_row();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    part.delete(); fullrows.delete(); fulllen.delete(); fullbank.delete(); expq.delete();
    bs = 1; be = 0; tile_ctr = 0; ovf_m = 1'b0; last_d = '0;
  endtask

  task automatic check_outputs();
    logic [1:0] bf;
    exp_t e;
    bf = 2'b00;
    foreach (fullbank[i]) bf[fullbank[i]] = 1'b1;
    chk("wr_ready", wr_ready_o, model_ready());
    chk("rd_busy", rd_busy_o, model_busy());
    chk("bank_full", bank_full_o, bf);
    chk("ovf_err", ovf_err_o, ovf_m);
    if (expq.size() > 0 && expq[0].t == cyc) begin
      e = expq.pop_front();
      chk("rd_valid", rd_valid_o, 1);
      chk("rd_data", rd_data_o, e.d);
      chk("rd_last", rd_last_o, e.l);
      last_d = e.d;
    end else begin
      chk("rd_valid_idle", rd_valid_o, 0);
      chk("rd_last_idle", rd_last_o, 0);
      chk("rd_data_hold", rd_data_o, last_d);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_wr_ready", wr_ready_o, 1);
    chk("rst_rd_busy", rd_busy_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_rd_last", rd_last_o, 0);
    chk("rst_bank_full", bank_full_o, 0);
    chk("rst_ovf_err", ovf_err_o, 0);
  endtask

  // One clock: drive inputs, predict acceptance from the model, advance, then check.
  task automatic tick(input bit wv, input row_t wd, input bit wl, input bit rs);
    bit   wacc, racc, dummy;
    int   n;
    exp_t e;
    wr_valid_i = wv; wr_data_i = wd; wr_last_i = wl; rd_start_i = rs;
    wacc = wv && model_ready();
    racc = rs && !model_busy() && (fulllen.size() > 0);
    @(posedge clk_i);
    cyc++;
    if (racc) begin
      n = fulllen.pop_front();
      dummy = fullbank.pop_front();
      bs = cyc; be = cyc + n - 1;
      for (int j = 0; j < n; j++) begin
        e.t = cyc + 1 + j;
        e.d = fullrows.pop_front();
        e.l = (j == n - 1);
        expq.push_back(e);
      end
    end
    if (wacc) begin
      part.push_back(wd);
      if (wl || part.size() == DEPTH) begin
        if (!wl) ovf_m = 1'b1;
        fulllen.push_back(part.size());
        fullbank.push_back(tile_ctr[0]);
        tile_ctr++;
        foreach (part[i]) fullrows.push_back(part[i]);
        part.delete();
      end
    end
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, rnd_row(), 1'b0, 1'b0);
  endtask

  task automatic drain_all();
    repeat (3) begin
      tick(1'b0, rnd_row(), 1'b0, 1'b1);
      idle(DEPTH + 2);
    end
  endtask

  task automatic write_tile(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, rnd_row(), i == n - 1, 1'b0);
  endtask

  initial begin
    row_t x;
    bit   done;

    model_reset();
    repeat (3) @(negedge clk_i);
    check_reset_values();
    check_outputs();
    rst_ni = 1'b1;
    idle(2);

    // Fill/drain: three patterned rows, last on the third.
    tick(1'b1, {N_COLS{16'h1111}}, 1'b0, 1'b0);
    tick(1'b1, {N_COLS{16'h2222}}, 1'b0, 1'b0);
    tick(1'b1, {N_COLS{16'h3333}}, 1'b1, 1'b0);
    idle(1);
    tick(1'b0, '0, 1'b0, 1'b1);
    idle(5);

    // Ping-pong: full-depth tile closed by wr_last, drain it while writing a 2-row tile.
    write_tile(DEPTH);
    tick(1'b1, rnd_row(), 1'b0, 1'b1);
    tick(1'b1, rnd_row(), 1'b1, 1'b0);
    idle(DEPTH + 1);
    tick(1'b0, '0, 1'b0, 1'b1);
    idle(5);

    // Backpressure: both banks full, a held 1-row beat lands only after one drain.
    write_tile(2);
    write_tile(2);
    x = rnd_row();
    repeat (3) tick(1'b1, x, 1'b1, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      done = model_ready();
      tick(1'b1, x, 1'b1, i == 0);
    end
    chk("held_beat_accepted", done, 1);
    wr_valid_i = 1'b0;
    drain_all();

    // Overflow: five beats without wr_last, then close the spill-over tile.
    for (int i = 0; i < 5; i++) tick(1'b1, rnd_row(), 1'b0, 1'b0);
    tick(1'b1, rnd_row(), 1'b1, 1'b0);
    drain_all();

    // Ignored starts: nothing full, then repeated starts during an active drain.
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b1);
    write_tile(3);
    for (int i = 0; i < 6; i++) tick(1'b0, rnd_row(), 1'b0, 1'b1);
    idle(3);

    // Reset on the second rd_valid of a 4-row drain.
    write_tile(4);
    idle(1);
    tick(1'b0, '0, 1'b0, 1'b1);
    idle(2);
    chk("second_valid_before_reset", rd_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check_outputs();
    idle(2);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 9) < 7, rnd_row(), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    wr_valid_i = 1'b0;
    drain_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
